// File: rtl/datapath.sv
// Execution datapath of the simple RISC CPU: register file, A/B operand registers,
// B-operand shifter, ALU, result register C and Z/N/V status flags.
module datapath (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  readnum,
  input  logic [3:0]  vsel,
  input  logic        loada,
  input  logic        loadb,
  input  logic [1:0]  shift,
  input  logic        asel,
  input  logic        bsel,
  input  logic [1:0]  ALUop,
  input  logic        loadc,
  input  logic        loads,
  input  logic [2:0]  writenum,
  input  logic        write,
  input  logic [15:0] sximm8,
  input  logic [15:0] sximm5,
  input  logic [15:0] mdata,
  input  logic [8:0]  PC,
  output logic        Z_out,
  output logic [15:0] datapath_out,
  output logic        V_out,
  output logic        N_out
);

  localparam logic [3:0] VSEL_IMM8 = 4'b0001;
  localparam logic [3:0] VSEL_C    = 4'b0010;
  localparam logic [3:0] VSEL_PC   = 4'b0100;
  localparam logic [3:0] VSEL_MEM  = 4'b1000;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL  = 2'b01;
  localparam logic [1:0] SH_LSR  = 2'b10;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;

  logic [15:0] regs [8];
  logic [15:0] a_reg;
  logic [15:0] b_reg;
  logic [15:0] c_reg;
  logic        z_reg;
  logic        n_reg;
  logic        v_reg;

  logic [15:0] data_in;
  logic [15:0] read_data;
  logic [15:0] shift_out;
  logic [15:0] ain;
  logic [15:0] bin;
  logic [15:0] alu_out;
  logic        alu_v;

  // Write-back source; anything other than a clean one-hot writes zero.
  always_comb begin
    data_in = 16'h0000;
    case (vsel)
      VSEL_IMM8: data_in = sximm8;
      VSEL_C:    data_in = c_reg;
      VSEL_PC:   data_in = {7'b0, PC};
      VSEL_MEM:  data_in = mdata;
      default:   data_in = 16'h0000;
    endcase
  end

  assign read_data = regs[readnum];

  always_comb begin
    shift_out = b_reg;
    case (shift)
      SH_NONE: shift_out = b_reg;
      SH_LSL:  shift_out = {b_reg[14:0], 1'b0};
      SH_LSR:  shift_out = {1'b0, b_reg[15:1]};
      default: shift_out = {b_reg[15], b_reg[15:1]};
    endcase
  end

  assign ain = asel ? 16'h0000 : a_reg;
  assign bin = bsel ? sximm5 : shift_out;

  // Overflow: operands of equal effective sign producing a result of the other sign.
  always_comb begin
    alu_out = 16'h0000;
    alu_v   = 1'b0;
    case (ALUop)
      OP_ADD: begin
        alu_out = ain + bin;
        alu_v   = (ain[15] == bin[15]) && (alu_out[15] != ain[15]);
      end
      OP_SUB: begin
        alu_out = ain - bin;
        alu_v   = (ain[15] != bin[15]) && (alu_out[15] != ain[15]);
      end
      OP_AND: begin
        alu_out = ain & bin;
        alu_v   = 1'b0;
      end
      default: begin
        alu_out = ~bin;
        alu_v   = 1'b0;
      end
    endcase
  end

  // A and B sample read_data before the same-edge register write lands.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) regs[i] <= 16'h0000;
      a_reg <= 16'h0000;
      b_reg <= 16'h0000;
      c_reg <= 16'h0000;
      z_reg <= 1'b0;
      n_reg <= 1'b0;
      v_reg <= 1'b0;
    end else begin
      if (write) regs[writenum] <= data_in;
      if (loada) a_reg <= read_data;
      if (loadb) b_reg <= read_data;
      if (loadc) c_reg <= alu_out;
      if (loads) begin
        z_reg <= (alu_out == 16'h0000);
        n_reg <= alu_out[15];
        v_reg <= alu_v;
      end
    end
  end

  assign datapath_out = c_reg;
  assign Z_out        = z_reg;
  assign N_out        = n_reg;
  assign V_out        = v_reg;

endmodule

// File: tb/tb_datapath.sv
// Directed bench for datapath: each task drives one scenario and checks the
// outputs against hand-computed values.
module tb_datapath;

  logic        clk;
  logic        reset;
  logic [2:0]  readnum;
  logic [3:0]  vsel;
  logic        loada;
  logic        loadb;
  logic [1:0]  shift;
  logic        asel;
  logic        bsel;
  logic [1:0]  ALUop;
  logic        loadc;
  logic        loads;
  logic [2:0]  writenum;
  logic        write;
  logic [15:0] sximm8;
  logic [15:0] sximm5;
  logic [15:0] mdata;
  logic [8:0]  PC;
  logic        Z_out;
  logic [15:0] datapath_out;
  logic        V_out;
  logic        N_out;

  int total;
  int bad;
  logic [15:0] exp_q[$];

  datapath dut (
    .clk(clk), .reset(reset), .readnum(readnum), .vsel(vsel),
    .loada(loada), .loadb(loadb), .shift(shift), .asel(asel), .bsel(bsel),
    .ALUop(ALUop), .loadc(loadc), .loads(loads), .writenum(writenum),
    .write(write), .sximm8(sximm8), .sximm5(sximm5), .mdata(mdata), .PC(PC),
    .Z_out(Z_out), .datapath_out(datapath_out), .V_out(V_out), .N_out(N_out)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic idle();
    readnum = 3'd0; vsel = 4'b0000; loada = 1'b0; loadb = 1'b0;
    shift = 2'b00; asel = 1'b0; bsel = 1'b0; ALUop = 2'b00;
    loadc = 1'b0; loads = 1'b0; writenum = 3'd0; write = 1'b0;
    sximm8 = 16'h0; sximm5 = 16'h0; mdata = 16'h0; PC = 9'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic write_imm(input logic [2:0] r, input logic [15:0] v);
    vsel = 4'b0001; sximm8 = v; writenum = r; write = 1'b1;
    tick();
  endtask

  task automatic load_a(input logic [2:0] r);
    readnum = r; loada = 1'b1;
    tick();
  endtask

  task automatic load_b(input logic [2:0] r);
    readnum = r; loadb = 1'b1;
    tick();
  endtask

  // Move A + 0 into C without touching flags.
  task automatic a_to_c();
    asel = 1'b0; bsel = 1'b1; sximm5 = 16'h0; ALUop = 2'b00; loadc = 1'b1;
    tick();
  endtask

  task automatic read_reg(input logic [2:0] r, output logic [15:0] v);
    load_a(r);
    a_to_c();
    v = datapath_out;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b0;
    #1;
    total++;
    if (datapath_out !== 16'h0 || {Z_out, N_out, V_out} !== 3'b000) begin
      bad++;
      $display("FAIL reset_during: out=%h znv=%b required 0000/000", datapath_out, {Z_out, N_out, V_out});
    end
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    tick();
    total++;
    if (datapath_out !== 16'h0 || {Z_out, N_out, V_out} !== 3'b000) begin
      bad++;
      $display("FAIL reset_after: out=%h znv=%b required 0000/000", datapath_out, {Z_out, N_out, V_out});
    end
    load_a(3'd3);
    load_b(3'd3);
    ALUop = 2'b00; loadc = 1'b1;
    tick();
    total++;
    if (datapath_out !== 16'h0) begin
      bad++;
      $display("FAIL reset_read_r3: got=%h required 0000", datapath_out);
    end
  endtask

  task automatic test_add_shift();
    logic [15:0] v;
    write_imm(3'd0, 16'd7);
    write_imm(3'd1, 16'd2);
    load_a(3'd0);
    load_b(3'd1);
    shift = 2'b01; ALUop = 2'b00; loadc = 1'b1;
    tick();
    total++;
    if (datapath_out !== 16'd11) begin
      bad++;
      $display("FAIL add_shift: got=%0d required 11", datapath_out);
    end
    vsel = 4'b0010; writenum = 3'd2; write = 1'b1;
    tick();
    read_reg(3'd2, v);
    total++;
    if (v !== 16'd11) begin
      bad++;
      $display("FAIL c_writeback_r2: got=%0d required 11", v);
    end
  endtask

  task automatic test_compare();
    write_imm(3'd4, 16'd5);
    load_a(3'd4);
    load_b(3'd4);
    ALUop = 2'b01; loads = 1'b1;
    tick();
    total++;
    if ({Z_out, N_out, V_out} !== 3'b100 || datapath_out !== 16'd11) begin
      bad++;
      $display("FAIL cmp_equal: znv=%b out=%h required 100/000b", {Z_out, N_out, V_out}, datapath_out);
    end
    write_imm(3'd5, 16'h7FFF);
    write_imm(3'd6, 16'h0001);
    load_a(3'd5);
    load_b(3'd6);
    ALUop = 2'b00; loads = 1'b1;
    tick();
    total++;
    if ({Z_out, N_out, V_out} !== 3'b011) begin
      bad++;
      $display("FAIL add_overflow: znv=%b required 011", {Z_out, N_out, V_out});
    end
    // 0x8000 - 1 = 0x7FFF, negative minus positive giving positive
    write_imm(3'd5, 16'h8000);
    load_a(3'd5);
    ALUop = 2'b01; loads = 1'b1; loadc = 1'b1;
    tick();
    total++;
    if ({Z_out, N_out, V_out} !== 3'b001 || datapath_out !== 16'h7FFF) begin
      bad++;
      $display("FAIL sub_overflow: znv=%b out=%h required 001/7fff", {Z_out, N_out, V_out}, datapath_out);
    end
  endtask

  task automatic test_move();
    write_imm(3'd7, 16'h8004);
    load_b(3'd7);
    asel = 1'b1; shift = 2'b10; ALUop = 2'b00; loadc = 1'b1;
    tick();
    total++;
    if (datapath_out !== 16'h4002) begin
      bad++;
      $display("FAIL lsr: got=%h required 4002", datapath_out);
    end
    asel = 1'b1; shift = 2'b11; ALUop = 2'b00; loadc = 1'b1;
    tick();
    total++;
    if (datapath_out !== 16'hC002) begin
      bad++;
      $display("FAIL asr: got=%h required c002", datapath_out);
    end
    write_imm(3'd7, 16'h00F0);
    load_b(3'd7);
    ALUop = 2'b11; loadc = 1'b1; loads = 1'b1;
    tick();
    total++;
    if (datapath_out !== 16'hFF0F || {Z_out, N_out, V_out} !== 3'b010) begin
      bad++;
      $display("FAIL not: got=%h znv=%b required ff0f/010", datapath_out, {Z_out, N_out, V_out});
    end
    write_imm(3'd0, 16'd10);
    load_a(3'd0);
    bsel = 1'b1; sximm5 = 16'hFFFC; ALUop = 2'b00; loadc = 1'b1;
    tick();
    total++;
    if (datapath_out !== 16'd6) begin
      bad++;
      $display("FAIL add_imm5: got=%h required 0006", datapath_out);
    end
    bsel = 1'b1; sximm5 = 16'h0003; ALUop = 2'b10; loadc = 1'b1;
    tick();
    total++;
    if (datapath_out !== 16'h0002) begin
      bad++;
      $display("FAIL and_imm5: got=%h required 0002", datapath_out);
    end
  endtask

  task automatic test_writeback();
    logic [15:0] v;
    mdata = 16'hABCD; vsel = 4'b1000; writenum = 3'd5; write = 1'b1;
    tick();
    exp_q.push_back(16'hABCD);
    PC = 9'h1FF; vsel = 4'b0100; writenum = 3'd6; write = 1'b1;
    tick();
    exp_q.push_back(16'h01FF);
    sximm8 = 16'h1234; vsel = 4'b0011; writenum = 3'd1; write = 1'b1;
    tick();
    exp_q.push_back(16'h0000);
    for (int i = 0; i < 3; i++) begin
      logic [15:0] e;
      logic [2:0]  r;
      r = (i == 0) ? 3'd5 : (i == 1) ? 3'd6 : 3'd1;
      read_reg(r, v);
      e = exp_q.pop_front();
      total++;
      if (v !== e) begin
        bad++;
        $display("FAIL writeback_r%0d: got=%h required %h", r, v, e);
      end
    end
  endtask

  task automatic test_same_cycle();
    logic [15:0] v;
    write_imm(3'd3, 16'h1111);
    vsel = 4'b0001; sximm8 = 16'h2222; writenum = 3'd3; write = 1'b1;
    readnum = 3'd3; loada = 1'b1;
    tick();
    a_to_c();
    total++;
    if (datapath_out !== 16'h1111) begin
      bad++;
      $display("FAIL same_cycle_old: got=%h required 1111", datapath_out);
    end
    read_reg(3'd3, v);
    total++;
    if (v !== 16'h2222) begin
      bad++;
      $display("FAIL same_cycle_new: got=%h required 2222", v);
    end
  endtask

  task automatic test_hold();
    ALUop = 2'b11; asel = 1'b1;
    repeat (3) tick();
    total++;
    if (datapath_out !== 16'h2222) begin
      bad++;
      $display("FAIL hold: got=%h required 2222", datapath_out);
    end
  endtask

  task automatic test_async_reset();
    logic [15:0] v;
    write_imm(3'd2, 16'h8001);
    load_a(3'd2);
    ALUop = 2'b00; bsel = 1'b1; sximm5 = 16'h0; loadc = 1'b1; loads = 1'b1;
    tick();
    total++;
    if (datapath_out !== 16'h8001 || N_out !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset: got=%h n=%b required 8001/1", datapath_out, N_out);
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if (datapath_out !== 16'h0 || {Z_out, N_out, V_out} !== 3'b000) begin
      bad++;
      $display("FAIL async_reset: out=%h znv=%b required 0000/000", datapath_out, {Z_out, N_out, V_out});
    end
    #2 reset = 1'b1;
    tick();
    read_reg(3'd2, v);
    total++;
    if (v !== 16'h0) begin
      bad++;
      $display("FAIL reset_clears_regs: got=%h required 0000", v);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_add_shift();
    test_compare();
    test_move();
    test_writeback();
    test_same_cycle();
    test_hold();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
